mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter that shares one single-port, read-first block RAM between the pipeline's instruction-fetch stage and its MEM (load/store) stage. Each stage keeps a request/grant interface and receives read data back on its own port. The block tracks in-flight reads across the fixed RAM read latency and drops fetch responses killed by a branch-redirect flush. It sits between the pipeline control in the top level and the shared RAM instance.

## Interface
Parameters:
- ADDR_W, 12, word-address width into the RAM.
- DATA_W, 32, data width.
- RD_LATENCY, 2, RAM read latency in cycles (2 = HIGH_PERFORMANCE output register); legal range 1..4.
- MAX_STREAK, 4, consecutive data grants allowed while fetch waits (only used with ARB_FAIR_EN); legal range 1..15.

Ports:
- clk_in  input  1  system clock; all state on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- if_req_in  input  1  fetch read request; held until granted.
- if_addr_in  input  ADDR_W  fetch word address.
- if_flush_in  input  1  branch redirect; kill all in-flight fetch reads.
- if_gnt_out  output  1  fetch request accepted this cycle.
- if_rvalid_out  output  1  fetch read data valid.
- if_rdata_out  output  DATA_W  fetch read data.
- d_req_in  input  1  data request; held until granted.
- d_we_in  input  1  1 = store, 0 = load.
- d_addr_in  input  ADDR_W  data word address.
- d_wdata_in  input  DATA_W  store data.
- d_gnt_out  output  1  data request accepted this cycle.
- d_rvalid_out  output  1  load data valid.
- d_rdata_out  output  DATA_W  load data.
- mem_en_out  output  1  RAM enable.
- mem_we_out  output  1  RAM write enable.
- mem_addr_out  output  ADDR_W  RAM address.
- mem_din_out  output  DATA_W  RAM write data.
- mem_dout_in  input  DATA_W  RAM read data.

## Operation
- Grant is decided each cycle. At most one grant per cycle.
  - Only d_req_in high: grant data.
  - Only if_req_in high: grant fetch.
  - Both high: data wins, unless the fairness rule applies (see Configuration).
- if_gnt_out is forced to 0 in any cycle where if_flush_in=1. d_gnt_out is unaffected by flush.
- Granted port drives the RAM:
  - mem_en_out=1.
  - mem_addr_out = winning address.
  - mem_we_out = d_we_in if data was granted, else 0.
  - mem_din_out = d_wdata_in.
- No grant: mem_en_out=0, mem_we_out=0, mem_addr_out=0, mem_din_out=0.
- In-flight tracker: a shift register of RD_LATENCY entries, each {valid, owner}.
  - A granted read (fetch, or data with we=0) enters stage 0 as valid with its owner.
  - Stores and idle cycles enter as invalid.
- Last tracker stage drives the response:
  - valid & owner=IF raises if_rvalid_out; valid & owner=D raises d_rvalid_out.
  - The matching rdata output = mem_dout_in; the non-valid port's rdata output = 0.
- Flush: when if_flush_in=1, every tracker entry with owner=IF is cleared on that clock edge, so its if_rvalid_out never asserts. A fetch response already presented in the flush cycle is still presented in that cycle; the requester ignores it. Data entries are never touched.

## Timing
- Paths req → gnt and req → mem_* are combinational, same cycle.
- Read response: rvalid is high exactly RD_LATENCY cycles after the grant cycle, for one cycle.
- Full throughput: one grant per cycle, back-to-back. A response and a new grant may occur in the same cycle.
- Reset: assertion of rst_n_in asynchronously clears the tracker and streak counter.
  - Consequences: all rvalid outputs are 0 and all rdata outputs are 0 immediately.
  - Grant outputs follow the request inputs combinationally during and after reset.
  - Reads in flight at reset never produce a response.

## Configuration
- ARB_FAIR_EN defined: streak counter, width 4, saturating at MAX_STREAK.
  - Increments on each data grant while if_req_in=1 and if_flush_in=0.
  - Clears when fetch is granted or when if_req_in=0.
  - With both requesting and counter==MAX_STREAK, fetch is granted and the counter clears.
- ARB_FAIR_EN undefined: strict data priority. No counter exists, and fetch can starve indefinitely.

## Test plan
- Fetch only: if_req at addresses 0,1,2,3 on cycles 0–3, RAM preloaded with mem[i]=0x100+i, RD_LATENCY=2 → if_gnt on cycles 0–3; if_rvalid on cycles 2–5 with 0x100..0x103.
- Contention, ARB_FAIR_EN, MAX_STREAK=4, both requesting continuously → grant pattern D,D,D,D,F repeating. Without the macro → d_gnt every cycle, if_gnt never.
- Store: d_req=1, d_we=1, addr 5, wdata 0xDEADBEEF → that cycle mem_we_out=1, mem_addr_out=5, no d_rvalid ever. A load from addr 5 on the next cycle → d_rvalid 2 cycles later with 0xDEADBEEF.
- Flush: fetch granted on cycles 0 and 1, load granted on cycle 2, if_flush_in=1 on cycle 2 → if_rvalid on cycle 2 (presented before the kill, ignored by the requester), no if_rvalid on cycle 3, d_rvalid on cycle 4, if_gnt=0 on cycle 2.
- Reset mid-operation: two reads in flight, rst_n_in low for 1 cycle then released → rvalid outputs 0 immediately, and no rvalid in the following 4 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one read-first block RAM between fetch and MEM.
// Optional fetch-fairness streak limiter enabled by macro ARB_FAIR_EN.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              if_flush_in,
  output logic              if_gnt_out,
  output logic              if_rvalid_out,
  output logic [DATA_W-1:0] if_rdata_out,
  input  logic              d_req_in,
  input  logic              d_we_in,
  input  logic [ADDR_W-1:0] d_addr_in,
  input  logic [DATA_W-1:0] d_wdata_in,
  output logic              d_gnt_out,
  output logic              d_rvalid_out,
  output logic [DATA_W-1:0] d_rdata_out,
  output logic              mem_en_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_din_out,
  input  logic [DATA_W-1:0] mem_dout_in
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4 || MAX_STREAK < 1 || MAX_STREAK > 15) begin : g_param_err
    $error("mem_port_arbiter: RD_LATENCY or MAX_STREAK out of range");
  end

  logic w_fetch_ok;
  logic w_force_if;
  logic w_if_gnt;
  logic w_d_gnt;
  logic w_rd_push;
  logic w_last_vld;
  logic w_last_if;

  logic [RD_LATENCY-1:0] r_vld;
  logic [RD_LATENCY-1:0] r_own;
  logic [RD_LATENCY-1:0] w_vld_nxt;
  logic [RD_LATENCY-1:0] w_own_nxt;

  // A flushed fetch is never eligible, so data may take the slot instead.
  assign w_fetch_ok = if_req_in & ~if_flush_in;
  assign w_d_gnt    = d_req_in & ~w_force_if;
  assign w_if_gnt   = w_fetch_ok & (~d_req_in | w_force_if);
  assign w_rd_push  = w_if_gnt | (w_d_gnt & ~d_we_in);

`ifdef ARB_FAIR_EN
  localparam logic [3:0] c_streak_max = 4'(MAX_STREAK);

  logic [3:0] r_streak;
  logic [3:0] w_streak_nxt;

  assign w_force_if = w_fetch_ok & (r_streak == c_streak_max);

  always_comb begin
    w_streak_nxt = r_streak;
    if (w_if_gnt || !if_req_in) begin
      w_streak_nxt = 4'd0;
    end else if (w_d_gnt && !if_flush_in && (r_streak != c_streak_max)) begin
      w_streak_nxt = r_streak + 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_streak <= 4'd0;
    end else begin
      r_streak <= w_streak_nxt;
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  // Tracker stage 0 takes the new grant; later stages shift, dropping
  // fetch entries on a flush edge.
  assign w_vld_nxt[0] = w_rd_push;
  assign w_own_nxt[0] = w_if_gnt;

  for (genvar g = 1; g < RD_LATENCY; g++) begin : g_stage
    assign w_vld_nxt[g] = r_vld[g-1] & ~(if_flush_in & r_own[g-1]);
    assign w_own_nxt[g] = r_own[g-1];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vld <= '0;
      r_own <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      r_own <= w_own_nxt;
    end
  end

  assign w_last_vld = r_vld[RD_LATENCY-1];
  assign w_last_if  = r_own[RD_LATENCY-1];

  assign if_gnt_out    = w_if_gnt;
  assign d_gnt_out     = w_d_gnt;
  assign if_rvalid_out = w_last_vld & w_last_if;
  assign d_rvalid_out  = w_last_vld & ~w_last_if;
  assign if_rdata_out  = (w_last_vld & w_last_if)  ? mem_dout_in : '0;
  assign d_rdata_out   = (w_last_vld & ~w_last_if) ? mem_dout_in : '0;

  assign mem_en_out   = w_if_gnt | w_d_gnt;
  assign mem_we_out   = w_d_gnt & d_we_in;
  assign mem_addr_out = w_d_gnt ? d_addr_in : (w_if_gnt ? if_addr_in : '0);
  assign mem_din_out  = (w_if_gnt | w_d_gnt) ? d_wdata_in : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: randomized and directed checks against a queue model.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req, if_flush, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_gnt_out, if_rvalid_out, d_gnt_out, d_rvalid_out;
  logic [DW-1:0] if_rdata_out, d_rdata_out, mem_din_out, mem_dout;
  logic          mem_en_out, mem_we_out;
  logic [AW-1:0] mem_addr_out;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .MAX_STREAK(MAXS)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .if_req_in(if_req), .if_addr_in(if_addr), .if_flush_in(if_flush),
    .if_gnt_out(if_gnt_out), .if_rvalid_out(if_rvalid_out), .if_rdata_out(if_rdata_out),
    .d_req_in(d_req), .d_we_in(d_we), .d_addr_in(d_addr), .d_wdata_in(d_wdata),
    .d_gnt_out(d_gnt_out), .d_rvalid_out(d_rvalid_out), .d_rdata_out(d_rdata_out),
    .mem_en_out(mem_en_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_din_out(mem_din_out), .mem_dout_in(mem_dout)
  );

  // Read-first RAM with a two-cycle read pipeline.
  logic [DW-1:0] ram [0:4095];
  logic [DW-1:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    if (mem_en_out) begin
      rd_p1 <= ram[mem_addr_out];
      if (mem_we_out) ram[mem_addr_out] <= mem_din_out;
    end
    rd_p2 <= rd_p1;
  end
  assign mem_dout = rd_p2;

  typedef struct {
    int          due;
    bit          own_if;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         q[$];
  logic [DW-1:0] ref_mem [0:4095];
  int            cyc = 0;
  int            streak = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic          e_ig, e_dg;
  logic [AW-1:0] e_addr;
  logic [113:0]  e_bus;
  logic [113:0]  act_bus;

  assign act_bus = {if_gnt_out, d_gnt_out, mem_en_out, mem_we_out, mem_addr_out, mem_din_out,
                    if_rvalid_out, if_rdata_out, d_rvalid_out, d_rdata_out};

  function automatic void predict();
    logic fok, frc, en, we, ir, dr;
    logic [DW-1:0] din, ird, drd;
    fok = if_req && !if_flush;
    frc = 1'b0;
`ifdef ARB_FAIR_EN
    frc = fok && (streak >= MAXS);
`endif
    e_dg   = d_req && !frc;
    e_ig   = fok && (!d_req || frc);
    en     = e_ig || e_dg;
    we     = e_dg && d_we;
    e_addr = e_dg ? d_addr : (e_ig ? if_addr : '0);
    din    = en ? d_wdata : '0;
    ir = 1'b0; dr = 1'b0; ird = '0; drd = '0;
    foreach (q[k]) begin
      if (q[k].due == cyc) begin
        if (q[k].own_if) begin ir = 1'b1; ird = q[k].data; end
        else begin dr = 1'b1; drd = q[k].data; end
      end
    end
    e_bus = {e_ig, e_dg, en, we, e_addr, din, ir, ird, dr, drd};
  endfunction

  task automatic commit();
    resp_t nq[$];
    if (e_ig || (e_dg && !d_we)) q.push_back('{cyc + LAT, e_ig, ref_mem[e_addr]});
    if (e_dg && d_we) ref_mem[d_addr] = d_wdata;
    foreach (q[k]) if (q[k].due > cyc && !(if_flush && q[k].own_if)) nq.push_back(q[k]);
    q = nq;
`ifdef ARB_FAIR_EN
    if (e_ig || !if_req) streak = 0;
    else if (e_dg && !if_flush && streak < MAXS) streak++;
`endif
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    predict();
    if (act_bus !== e_bus) begin n_err++; $display("FAIL reset_idle act=%h exp=%h", act_bus, e_bus); end
    n_vec++;
    d_req = 1; d_addr = 12'd3;
    #1;
    if ({d_gnt_out, mem_en_out, if_rvalid_out, d_rvalid_out} !== 4'b1100) begin
      n_err++; $display("FAIL reset_gnt act=%b exp=1100", {d_gnt_out, mem_en_out, if_rvalid_out, d_rvalid_out});
    end
    n_vec++;
    @(posedge clk); #1;
    rst_n = 1; idle_inputs();
  endtask

  task automatic test_fetch_only();
    for (int i = 0; i < 16; i++) begin
      idle_inputs(); d_req = 1; d_we = 1; d_addr = AW'(i); d_wdata = 32'h100 + 32'(i);
      @(negedge clk); predict();
      if (act_bus !== e_bus) begin n_err++; $display("FAIL preload%0d act=%h exp=%h", i, act_bus, e_bus); end
      n_vec++;
      commit();
    end
    for (int k = 0; k < 7; k++) begin
      idle_inputs();
      if (k < 4) begin if_req = 1; if_addr = AW'(k); end
      @(negedge clk); predict();
      if (act_bus !== e_bus) begin n_err++; $display("FAIL fetch_bus%0d act=%h exp=%h", k, act_bus, e_bus); end
      n_vec++;
      if (if_gnt_out !== (k < 4)) begin n_err++; $display("FAIL fetch_gnt%0d act=%b", k, if_gnt_out); end
      n_vec++;
      if (k >= 2 && k <= 5) begin
        if (!if_rvalid_out || if_rdata_out !== 32'h100 + 32'(k - 2)) begin
          n_err++; $display("FAIL fetch_data%0d act=%b/%h exp=1/%h", k, if_rvalid_out, if_rdata_out, 32'h100 + 32'(k - 2));
        end
      end else if (if_rvalid_out !== 1'b0) begin
        n_err++; $display("FAIL fetch_norv%0d act=%b exp=0", k, if_rvalid_out);
      end
      n_vec++;
      commit();
    end
  endtask

  task automatic test_store_load();
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      if (k == 0) begin d_req = 1; d_we = 1; d_addr = 12'd5; d_wdata = 32'hDEADBEEF; end
      if (k == 1) begin d_req = 1; d_addr = 12'd5; end
      @(negedge clk); predict();
      if (act_bus !== e_bus) begin n_err++; $display("FAIL st_bus%0d act=%h exp=%h", k, act_bus, e_bus); end
      n_vec++;
      if (k == 0 && {mem_we_out, mem_addr_out} !== {1'b1, 12'd5}) begin
        n_err++; $display("FAIL st_we act=%b/%0d exp=1/5", mem_we_out, mem_addr_out);
      end
      if (k == 3 && {d_rvalid_out, d_rdata_out} !== {1'b1, 32'hDEADBEEF}) begin
        n_err++; $display("FAIL ld_data act=%b/%h exp=1/deadbeef", d_rvalid_out, d_rdata_out);
      end
      if (k != 3 && d_rvalid_out !== 1'b0) begin
        n_err++; $display("FAIL st_norv%0d act=%b exp=0", k, d_rvalid_out);
      end
      n_vec++;
      commit();
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      if (k < 3) begin if_req = 1; if_addr = AW'(8 + k); end
      if (k == 2) begin if_flush = 1; d_req = 1; d_addr = 12'd5; end
      @(negedge clk); predict();
      if (act_bus !== e_bus) begin n_err++; $display("FAIL fl_bus%0d act=%h exp=%h", k, act_bus, e_bus); end
      n_vec++;
      if (k == 2 && {if_gnt_out, d_gnt_out, if_rvalid_out, if_rdata_out} !== {3'b011, 32'h108}) begin
        n_err++; $display("FAIL fl_cyc2 act=%b%b%b/%h exp=011/108", if_gnt_out, d_gnt_out, if_rvalid_out, if_rdata_out);
      end
      if (k == 3 && if_rvalid_out !== 1'b0) begin
        n_err++; $display("FAIL fl_killed act=%b exp=0", if_rvalid_out);
      end
      if (k == 4 && {d_rvalid_out, d_rdata_out} !== {1'b1, 32'hDEADBEEF}) begin
        n_err++; $display("FAIL fl_dload act=%b/%h exp=1/deadbeef", d_rvalid_out, d_rdata_out);
      end
      n_vec++;
      commit();
    end
  endtask

  task automatic test_contention();
    logic exp_f;
    for (int i = 0; i < 13; i++) begin
      idle_inputs();
      if (i < 10) begin
        if_req = 1; d_req = 1; d_addr = AW'(i % 16); if_addr = AW'((i + 3) % 16);
      end
      @(negedge clk); predict();
      if (act_bus !== e_bus) begin n_err++; $display("FAIL ct_bus%0d act=%h exp=%h", i, act_bus, e_bus); end
      n_vec++;
      if (i < 10) begin
        exp_f = 1'b0;
`ifdef ARB_FAIR_EN
        exp_f = (i % 5 == 4);
`endif
        if ({if_gnt_out, d_gnt_out} !== {exp_f, !exp_f}) begin
          n_err++; $display("FAIL ct_pat%0d act=%b%b exp=%b%b", i, if_gnt_out, d_gnt_out, exp_f, !exp_f);
        end
        n_vec++;
      end
      commit();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 403; i++) begin
      idle_inputs();
      if (i < 400) begin
        if_req   = ($urandom_range(0, 9) < 7);
        d_req    = ($urandom_range(0, 9) < 7);
        d_we     = ($urandom_range(0, 3) == 0);
        if_flush = ($urandom_range(0, 9) == 0);
        if_addr  = AW'($urandom_range(0, 15));
        d_addr   = AW'($urandom_range(0, 15));
        d_wdata  = $urandom;
      end
      @(negedge clk); predict();
      if (act_bus !== e_bus) begin n_err++; $display("FAIL rnd%0d act=%h exp=%h", i, act_bus, e_bus); end
      n_vec++;
      commit();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      idle_inputs();
      if (k == 0) begin if_req = 1; if_addr = 12'd1; end
      else begin d_req = 1; d_addr = 12'd2; end
      @(negedge clk); predict();
      if (act_bus !== e_bus) begin n_err++; $display("FAIL rm_bus%0d act=%h exp=%h", k, act_bus, e_bus); end
      n_vec++;
      commit();
    end
    idle_inputs();
    if (if_rvalid_out !== 1'b1) begin n_err++; $display("FAIL rm_inflight act=%b exp=1", if_rvalid_out); end
    n_vec++;
    rst_n = 0; d_req = 1; d_addr = 12'd4;
    #1;
    if ({if_rvalid_out, d_rvalid_out, if_rdata_out, d_rdata_out, d_gnt_out} !== {66'd0, 1'b1}) begin
      n_err++; $display("FAIL rm_async act=%b%b/%h/%h gnt=%b exp=00/0/0 gnt=1",
                        if_rvalid_out, d_rvalid_out, if_rdata_out, d_rdata_out, d_gnt_out);
    end
    n_vec++;
    q.delete(); streak = 0;
    @(posedge clk); #1;
    rst_n = 1; idle_inputs(); cyc++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); predict();
      if (act_bus !== e_bus) begin n_err++; $display("FAIL rm_post%0d act=%h exp=%h", k, act_bus, e_bus); end
      n_vec++;
      if ({if_rvalid_out, d_rvalid_out} !== 2'b00) begin
        n_err++; $display("FAIL rm_norv%0d act=%b%b exp=00", k, if_rvalid_out, d_rvalid_out);
      end
      n_vec++;
      commit();
    end
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    test_reset();
    test_fetch_only();
    test_store_load();
    test_flush();
    test_contention();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
